// File: rtl/fetch_prefetch_unit_pkg.sv
// Shared fetch-stage constants: opcode field geometry, HALT encoding, default widths.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package fetch_prefetch_unit_pkg;

  // Default geometry of the fetch path
  localparam int ADDR_W_DEF  = 11;
  localparam int INSTR_W_DEF = 16;

  // The opcode occupies the top OPCODE_W bits of every instruction word
  localparam int OPCODE_W = 5;

  // Opcode encodings the fetch stage needs to recognise
  localparam logic [OPCODE_W-1:0] OP_NOP  = 5'b00000;
  localparam logic [OPCODE_W-1:0] OP_HALT = 5'b11111;

  // Returns 1 when the given instruction word carries the HALT opcode
  function automatic logic is_halt_opcode(input logic [OPCODE_W-1:0] opcode);
    return opcode == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_prefetch_unit_fifo.sv
// Prefetch queue: DEPTH x WIDTH registered FIFO with synchronous clear and occupancy count.
// Latency: a push at edge N is visible at the head from the cycle after edge N (no bypass).
// Backpressure: none internally; the caller must never push when full (checked by assertion).
module fetch_prefetch_unit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 27
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_dat,
  input  logic                     pop,
  input  logic                     clear,
  output logic                     head_vld,
  output logic [WIDTH-1:0]         head_dat,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic             full;

  // A clear wins over anything else that happens in the same cycle
  assign do_push  = push && !clear;
  assign do_pop   = pop && !clear && (count != '0);
  assign full     = (count == CW'(DEPTH));
  assign head_vld = (count != '0);
  assign head_dat = mem[rd_ptr];

  // Storage: reset to zero so the head outputs read as zero out of reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (do_push) begin
      mem[wr_ptr] <= push_dat;
    end
  end

  // Pointer and occupancy bookkeeping; simultaneous push and pop keeps the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // A push into a full queue means the upstream credit accounting is broken
  always_ff @(posedge clk) begin
    if (rst && do_push) begin
      assert (!full);
    end
  end

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues imem reads, queues words+PCs for decode.
// Latency: request in cycle t, data in t+1, word presented to decode (out_valid) in t+2.
// Backpressure: out_ready=0 holds the head; fetch continues until queue+inflight reaches DEPTH.
module fetch_prefetch_unit
  import fetch_prefetch_unit_pkg::*;
#(
  parameter int                ADDR_W   = ADDR_W_DEF,
  parameter int                INSTR_W  = INSTR_W_DEF,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  output logic                      imem_req,
  output logic [ADDR_W-1:0]         imem_addr,
  input  logic [INSTR_W-1:0]        imem_rdata,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [INSTR_W-1:0]        out_instr,
  output logic [ADDR_W-1:0]         out_pc,
  input  logic                      redirect_en,
  input  logic [ADDR_W-1:0]         redirect_addr,
  output logic                      halted,
  output logic [$clog2(DEPTH):0]    queue_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int DW = ADDR_W + INSTR_W;

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] issue_pc;
  logic              inflight;
  logic              halted_q;
  logic [CW-1:0]     count;
  logic [CW:0]       credit_used;
  logic              push;
  logic              pop;
  logic              halt_word;
  logic              fifo_vld;
  logic [DW-1:0]     fifo_head;

  // Every slot is either occupied or reserved by the read in flight
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight};

  // Gating with rst keeps the memory quiet while the block is held in reset
  assign imem_req  = rst && !halted_q && !redirect_en && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr = pc;

  // A returning word is kept unless a redirect flushes it or fetch has already halted
  assign push      = inflight && !redirect_en && !halted_q;
  assign halt_word = is_halt_opcode(imem_rdata[INSTR_W-1 -: OPCODE_W]);

  // The flush in a redirect cycle also swallows any pop decode attempted
  assign pop = fifo_vld && out_ready && !redirect_en;

  fetch_prefetch_unit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (DW)
  ) u_prefetch_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat ({issue_pc, imem_rdata}),
    .pop      (pop),
    .clear    (redirect_en),
    .head_vld (fifo_vld),
    .head_dat (fifo_head),
    .count    (count)
  );

  assign out_valid   = fifo_vld;
  assign out_pc      = fifo_head[DW-1 -: ADDR_W];
  assign out_instr   = fifo_head[INSTR_W-1:0];
  assign queue_count = count;
  assign halted      = halted_q;

  // PC: redirect target takes priority, otherwise advance (wrapping) on each issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc <= RESET_PC;
    end else if (redirect_en) begin
      pc <= redirect_addr;
    end else if (imem_req) begin
      pc <= pc + 1'b1;
    end
  end

  // Remember which PC the outstanding read belongs to
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inflight <= 1'b0;
      issue_pc <= RESET_PC;
    end else begin
      inflight <= imem_req;
      if (imem_req) begin
        issue_pc <= pc;
      end
    end
  end

  // Halt once a HALT word is queued; only a redirect restarts fetching
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else if (redirect_en) begin
      halted_q <= 1'b0;
    end else if (push && halt_word) begin
      halted_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: cycle table for stall/credit, scoreboard for delivery order.
// Latency: n/a (testbench).
// Backpressure: out_ready driven per scenario.
module tb_fetch_prefetch_unit;

  localparam int AW    = 11;
  localparam int IW    = 16;
  localparam int DEPTH = 4;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic [IW-1:0] imem_rdata = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [IW-1:0] out_instr;
  logic [AW-1:0] out_pc;
  logic          redirect_en = 1'b0;
  logic [AW-1:0] redirect_addr = '0;
  logic          halted;
  logic [CW-1:0] queue_count;

  fetch_prefetch_unit #(
    .ADDR_W   (AW),
    .INSTR_W  (IW),
    .DEPTH    (DEPTH),
    .RESET_PC (11'h000)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .redirect_en   (redirect_en),
    .redirect_addr (redirect_addr),
    .halted        (halted),
    .queue_count   (queue_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic          halt_en   = 1'b0;
  logic [AW-1:0] halt_addr = '0;
  bit            strict    = 1'b0;
  bit            track_gaps = 1'b0;
  bit            seen_vld  = 1'b0;
  int            gaps      = 0;

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [IW-1:0] instr;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic          rdy;
    int            cnt;
    logic          req;
    logic          vld;
    logic [AW-1:0] hpc;
  } vec_t;
  vec_t tbl [14];

  // Instruction memory contents: 16'h1000+a, or a HALT word at halt_addr
  function automatic logic [IW-1:0] memf(input logic [AW-1:0] a);
    if (halt_en && a == halt_addr) return 16'hF800 | {5'b0, a};
    return 16'h1000 + {5'b0, a};
  endfunction

  // Synchronous memory with one cycle of read latency
  always @(posedge clk) begin
    imem_rdata <= imem_req ? memf(imem_addr) : 16'hDEAD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h @%0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_seq(input logic [AW-1:0] start, input int n);
    logic [AW-1:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      sb.push_back({a, memf(a)});
      a = a + 1'b1;
    end
  endtask

  // One clock cycle: observe the handshake that completes at the coming edge
  task automatic cyc();
    exp_t e;
    #1;
    if (track_gaps) begin
      if (out_valid) seen_vld = 1'b1;
      else if (seen_vld) gaps++;
    end
    if (out_valid && out_ready && !redirect_en) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("sb_pc", 32'(out_pc), 32'(e.pc));
        chk("sb_instr", 32'(out_instr), 32'(e.instr));
      end else if (strict) begin
        total++;
        bad++;
        $display("FAIL sb_unexpected got pc=%0h instr=%0h want=no word @%0t", out_pc, out_instr, $time);
      end
    end
    @(negedge clk);
  endtask

  // Hold reset two cycles, check reset outputs, release at a falling edge (cycle 0 begins)
  task automatic do_reset();
    rst = 1'b0;
    out_ready = 1'b0;
    redirect_en = 1'b0;
    redirect_addr = '0;
    halt_en = 1'b0;
    strict = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_imem_req", 32'(imem_req), 0);
    chk("rst_queue_count", 32'(queue_count), 0);
    chk("rst_out_instr", 32'(out_instr), 0);
    chk("rst_out_pc", 32'(out_pc), 0);
    chk("rst_halted", 32'(halted), 0);
    @(negedge clk);
    sb.delete();
    rst = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout @%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    // Stall then release from reset: {out_ready, count, imem_req, out_valid, head pc}
    tbl[0]  = '{1'b0, 0, 1'b1, 1'b0, 11'h0};
    tbl[1]  = '{1'b0, 0, 1'b1, 1'b0, 11'h0};
    tbl[2]  = '{1'b0, 1, 1'b1, 1'b1, 11'h0};
    tbl[3]  = '{1'b0, 2, 1'b1, 1'b1, 11'h0};
    tbl[4]  = '{1'b0, 3, 1'b0, 1'b1, 11'h0};
    tbl[5]  = '{1'b0, 4, 1'b0, 1'b1, 11'h0};
    tbl[6]  = '{1'b0, 4, 1'b0, 1'b1, 11'h0};
    tbl[7]  = '{1'b0, 4, 1'b0, 1'b1, 11'h0};
    tbl[8]  = '{1'b0, 4, 1'b0, 1'b1, 11'h0};
    tbl[9]  = '{1'b0, 4, 1'b0, 1'b1, 11'h0};
    tbl[10] = '{1'b1, 4, 1'b0, 1'b1, 11'h0};
    tbl[11] = '{1'b1, 3, 1'b1, 1'b1, 11'h1};
    tbl[12] = '{1'b1, 2, 1'b1, 1'b1, 11'h2};
    tbl[13] = '{1'b1, 2, 1'b1, 1'b1, 11'h3};

    // Streaming with out_ready=1: one word per cycle from cycle 2, no gaps
    do_reset();
    out_ready = 1'b1;
    expect_seq(11'h000, 20);
    track_gaps = 1'b1;
    seen_vld = 1'b0;
    gaps = 0;
    #1;
    chk("s1_c0_req", 32'(imem_req), 1);
    chk("s1_c0_addr", 32'(imem_addr), 0);
    chk("s1_c0_vld", 32'(out_valid), 0);
    cyc();
    #1;
    chk("s1_c1_vld", 32'(out_valid), 0);
    cyc();
    #1;
    chk("s1_c2_vld", 32'(out_valid), 1);
    chk("s1_c2_pc", 32'(out_pc), 0);
    cyc();
    repeat (22) cyc();
    track_gaps = 1'b0;
    chk("s1_gaps", 32'(gaps), 0);
    chk("s1_drained", 32'(sb.size()), 0);

    // Stall for ten cycles then release, cycle by cycle from the table
    do_reset();
    expect_seq(11'h000, 12);
    for (int r = 0; r < 14; r++) begin
      out_ready = tbl[r].rdy;
      #1;
      chk($sformatf("s2_cnt_%0d", r), 32'(queue_count), 32'(tbl[r].cnt));
      chk($sformatf("s2_req_%0d", r), 32'(imem_req), 32'(tbl[r].req));
      chk($sformatf("s2_vld_%0d", r), 32'(out_valid), 32'(tbl[r].vld));
      if (tbl[r].vld) begin
        chk($sformatf("s2_hpc_%0d", r), 32'(out_pc), 32'(tbl[r].hpc));
        chk($sformatf("s2_hinstr_%0d", r), 32'(out_instr), 32'(memf(tbl[r].hpc)));
      end
      cyc();
    end
    out_ready = 1'b1;
    repeat (12) cyc();
    chk("s2_drained", 32'(sb.size()), 0);

    // Redirect to 0x200 while three words are queued and one is in flight
    do_reset();
    strict = 1'b1;
    repeat (4) cyc();
    #1;
    chk("s3_pre_cnt", 32'(queue_count), 3);
    redirect_en = 1'b1;
    redirect_addr = 11'h200;
    expect_seq(11'h200, 6);
    #1;
    chk("s3_req_in_redirect", 32'(imem_req), 0);
    cyc();
    redirect_en = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("s3_cnt_after", 32'(queue_count), 0);
    chk("s3_vld_after", 32'(out_valid), 0);
    chk("s3_req_t1", 32'(imem_req), 1);
    chk("s3_addr_t1", 32'(imem_addr), 32'h200);
    cyc();
    #1;
    chk("s3_vld_t2", 32'(out_valid), 0);
    cyc();
    #1;
    chk("s3_vld_t3", 32'(out_valid), 1);
    chk("s3_pc_t3", 32'(out_pc), 32'h200);
    cyc();
    repeat (5) cyc();
    strict = 1'b0;
    chk("s3_drained", 32'(sb.size()), 0);

    // HALT at address 5: words 0..5 only, then redirect to 0 resumes
    do_reset();
    halt_en = 1'b1;
    halt_addr = 11'h005;
    strict = 1'b1;
    out_ready = 1'b1;
    expect_seq(11'h000, 6);
    repeat (20) cyc();
    #1;
    chk("s4_halted", 32'(halted), 1);
    chk("s4_req_low", 32'(imem_req), 0);
    chk("s4_vld_low", 32'(out_valid), 0);
    chk("s4_cnt", 32'(queue_count), 0);
    chk("s4_drained", 32'(sb.size()), 0);
    redirect_en = 1'b1;
    redirect_addr = 11'h000;
    expect_seq(11'h000, 6);
    cyc();
    redirect_en = 1'b0;
    #1;
    chk("s4_unhalted", 32'(halted), 0);
    chk("s4_resume_req", 32'(imem_req), 1);
    chk("s4_resume_addr", 32'(imem_addr), 0);
    repeat (20) cyc();
    chk("s4_rehalted", 32'(halted), 1);
    chk("s4_drained2", 32'(sb.size()), 0);
    strict = 1'b0;
    halt_en = 1'b0;

    // PC wrap after redirect to 0x7FE
    do_reset();
    repeat (3) cyc();
    redirect_en = 1'b1;
    redirect_addr = 11'h7FE;
    cyc();
    redirect_en = 1'b0;
    out_ready = 1'b1;
    expect_seq(11'h7FE, 4);
    repeat (8) cyc();
    chk("s5_drained", 32'(sb.size()), 0);

    // Asynchronous reset mid-stream with three words queued
    do_reset();
    repeat (4) cyc();
    #1;
    chk("s6_pre_cnt", 32'(queue_count), 3);
    #2;
    rst = 1'b0;
    #1;
    chk("s6_async_vld", 32'(out_valid), 0);
    chk("s6_async_cnt", 32'(queue_count), 0);
    chk("s6_async_req", 32'(imem_req), 0);
    @(negedge clk);
    rst = 1'b1;
    out_ready = 1'b1;
    strict = 1'b1;
    expect_seq(11'h000, 4);
    #1;
    chk("s6_restart_req", 32'(imem_req), 1);
    chk("s6_restart_addr", 32'(imem_addr), 0);
    cyc();
    repeat (5) cyc();
    strict = 1'b0;
    chk("s6_drained", 32'(sb.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
